// File: rtl/sa_write_channel.sv
// Slave-port AXI4 write channel: AW arbitration, W steering through an order FIFO, B routing by BID prefix.
// Build option SA_WR_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
module sa_write_channel #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
  output logic [MST_AMT-1:0]                     dsp_WREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]     dsp_BRESP_o,
  output logic [MST_AMT-1:0]                     dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
  output logic                                   s_WLAST_o,
  output logic                                   s_WVALID_o,
  input  logic                                   s_WREADY_i,
  input  logic [TRANS_SLV_ID_W-1:0]              s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
  input  logic                                   s_BVALID_i,
  output logic                                   s_BREADY_o
);
  localparam int PTR_W = $clog2(OUTSTANDING_AMT);

  logic [MST_ID_W-1:0] win;
  logic                load;
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [MST_ID_W-1:0] order_mem [OUTSTANDING_AMT];
  logic                ofifo_full;
  logic                ofifo_empty;
  logic [MST_ID_W-1:0] head;
  logic                pop;
  logic [MST_ID_W-1:0] b_idx;

  // Full is judged on pre-pop pointers, so a same-cycle WLAST pop does not free a slot for AW.
  assign ofifo_empty = (wr_ptr == rd_ptr);
  assign ofifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign load = (!s_AWVALID_o || s_AWREADY_i) && !ofifo_full && (|dsp_AWVALID_i);

`ifdef SA_WR_ROUND_ROBIN_EN
  logic [MST_ID_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % MST_AMT;
      if (dsp_AWVALID_i[idx]) win = MST_ID_W'(idx);
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i)
      rr_ptr <= '0;
    else if (load)
      rr_ptr <= (int'(win) == MST_AMT - 1) ? '0 : win + MST_ID_W'(1);
  end
`else
  always_comb begin
    win = '0;
    for (int i = MST_AMT - 1; i >= 0; i--)
      if (dsp_AWVALID_i[i]) win = MST_ID_W'(i);
  end
`endif

  assign dsp_AWREADY_o = load ? (MST_AMT'(1) << win) : '0;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      s_AWVALID_o <= 1'b0;
      s_AWID_o    <= '0;
      s_AWADDR_o  <= '0;
      s_AWBURST_o <= '0;
      s_AWLEN_o   <= '0;
      s_AWSIZE_o  <= '0;
    end else if (load) begin
      s_AWVALID_o <= 1'b1;
      s_AWID_o    <= {win, dsp_AWID_i[int'(win)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
      s_AWADDR_o  <= dsp_AWADDR_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      s_AWBURST_o <= dsp_AWBURST_i[int'(win)*TRANS_BURST_W +: TRANS_BURST_W];
      s_AWLEN_o   <= dsp_AWLEN_i[int'(win)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      s_AWSIZE_o  <= dsp_AWSIZE_i[int'(win)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    end else if (s_AWREADY_i) begin
      s_AWVALID_o <= 1'b0;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (load) order_mem[wr_ptr[PTR_W-1:0]] <= win;
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (load) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // W beats follow AW grant order; only the head master sees WREADY.
  assign head         = order_mem[rd_ptr[PTR_W-1:0]];
  assign s_WVALID_o   = !ofifo_empty && dsp_WVALID_i[head];
  assign s_WDATA_o    = dsp_WDATA_i[int'(head)*DATA_WIDTH +: DATA_WIDTH];
  assign s_WLAST_o    = dsp_WLAST_i[head];
  assign dsp_WREADY_o = (!ofifo_empty && s_WREADY_i) ? (MST_AMT'(1) << head) : '0;
  assign pop          = s_WVALID_o && s_WREADY_i && s_WLAST_o;

  // An out-of-range prefix matches no dispatcher and is silently accepted.
  assign b_idx = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];

  always_comb begin
    dsp_BVALID_o = '0;
    s_BREADY_o   = 1'b1;
    for (int k = 0; k < MST_AMT; k++) begin
      if (int'(b_idx) == k) begin
        dsp_BVALID_o[k] = s_BVALID_i;
        s_BREADY_o      = dsp_BREADY_i[k];
      end
    end
  end

  assign dsp_BID_o   = {MST_AMT{s_BID_i[TRANS_MST_ID_W-1:0]}};
  assign dsp_BRESP_o = {MST_AMT{s_BRESP_i}};

endmodule
